fft_sink_feeder: RTL and testbench
==================================

FFT_SINK_FEEDER -- requirements
Module: fft_sink_feeder

Interface
REQ-001 Parameters SHALL be: FFT_LEN, 1024, samples per FFT frame; AW, 10, buffer address width (2^AW = FFT_LEN); DW, 12, sample width.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
REQ-003 Capture-side ports SHALL be:
- start  in  1  one-cycle request to capture and send one frame
- adc_valid  in  1  adc_data qualifier
- adc_data  in  DW  ADC sample, unsigned offset binary
REQ-004 FFT sink ports SHALL be:
- sink_ready  in  1  FFT accepts data
- sink_valid  out  1  sample valid
- sink_sop  out  1  first sample of frame
- sink_eop  out  1  last sample of frame
- sink_real  out  DW  two's-complement real part
- sink_imag  out  DW  imaginary part
- sink_error  out  2  error code
- sink_inverse  out  1  inverse-FFT select
REQ-005 Status ports SHALL be:
- busy  out  1  state is not IDLE
- frame_done  out  1  one-cycle pulse when the frame completes
- overrun  out  1  sticky flag for samples dropped in SEND

Function
REQ-006 The FSM SHALL have exactly three states: IDLE, CAPTURE and SEND.
REQ-007 IDLE SHALL move to CAPTURE on start=1 and clear the write counter and overrun; start in any other state SHALL be ignored.
REQ-008 In CAPTURE, each cycle with adc_valid=1 SHALL write adc_data XOR 0x800 to buffer[wcnt] and increment wcnt.
REQ-009 After the FFT_LEN-th accepted sample (wcnt = FFT_LEN-1 and adc_valid=1), the FSM SHALL move to SEND on the next cycle.
REQ-010 In IDLE, adc_valid SHALL be ignored; in SEND, adc_valid SHALL be ignored and SHALL set overrun.
REQ-011 In SEND, sink_real SHALL present buffer[k] for k = 0..FFT_LEN-1 in order.
REQ-012 In SEND, sink_imag SHALL be 0, sink_error SHALL be 2'b00 and sink_inverse SHALL be 0 at all times.
REQ-013 A transfer SHALL occur only in a cycle with sink_valid=1 and sink_ready=1; k SHALL advance only on a transfer.
REQ-014 While sink_valid=1 and sink_ready=0, sink_valid, sink_sop, sink_eop and sink_real SHALL hold stable.
REQ-015 sink_sop SHALL be 1 only with k=0, and sink_eop SHALL be 1 only with k=FFT_LEN-1; both SHALL be qualified by sink_valid.
REQ-016 The first sink_valid=1 SHALL occur no later than 3 cycles after the cycle in which the last sample was written.
REQ-017 With sink_ready held high, the block SHALL transfer one sample per cycle with no bubbles, i.e. FFT_LEN consecutive transfers.
REQ-018 sink_ready toggling SHALL cause neither loss nor duplication of samples.
REQ-019 On the eop transfer, sink_valid SHALL drop on the next cycle, frame_done SHALL pulse for exactly one cycle on that cycle, and the FSM SHALL return to IDLE.
REQ-020 start arriving in the same cycle as frame_done SHALL be ignored; the requester re-issues it.
REQ-021 The write and read counters SHALL be AW bits wide; wrap-around is never reached within a state because the FSM exits at FFT_LEN-1.
REQ-022 sink_valid SHALL never be asserted outside SEND.

Reset
REQ-023 Asserting rst_n=0 SHALL immediately force:
- state = IDLE
- wcnt = 0, k = 0
- sink_valid, sink_sop, sink_eop, frame_done, overrun, busy = 0
- sink_real = 0, sink_imag = 0
REQ-024 Reset asserted mid-CAPTURE or mid-SEND SHALL abandon the frame; no partial frame SHALL be resumed after reset.
REQ-025 Buffer contents SHALL NOT be reset.

Structure
REQ-026 FFT_LEN, AW, DW and the state encoding (IDLE/CAPTURE/SEND) SHALL be defined in a shared fft package, also used by the magnitude/display path.
REQ-027 The buffer SHALL be one sub-module, frame_ram: a simple dual-port RAM of depth 2^AW, width DW, with one write port, one read port and registered read (1-cycle latency).
REQ-028 The feeder SHALL use a 2-entry output skid/prefetch stage to meet REQ-014 and REQ-017 given the 1-cycle read latency.

Verification
REQ-029 Ramp frame: start, then 1024 samples adc_data = i with adc_valid=1 every cycle, sink_ready=1. Required: sink_real(k) = k XOR 0x800, i.e. k=0 -> 0x800 and k=2048 wrap not reached; exactly 1024 consecutive valid cycles; sop at k=0; eop at k=1023; one frame_done pulse.
REQ-030 Backpressure: same ramp with sink_ready pseudo-random at 50%. Required: same 1024-value sequence, no gaps or duplicates, outputs stable during every stall.
REQ-031 Sparse ADC: adc_valid=1 every 4th cycle. Required: SEND starts only after the 1024th valid sample, and first sink_valid within 3 cycles of that sample.
REQ-032 Overrun and ignored start: adc_valid=1 throughout SEND, plus start pulsed mid-SEND. Required: overrun=1 until the next accepted start, frame output unaffected, no second frame started.
REQ-033 Reset mid-SEND: assert rst_n=0 at k=500 for 2 cycles. Required: all outputs 0 and IDLE immediately; a new start yields a complete, correct frame with sop.

Source files
------------

// File: rtl/fft_sink_feeder_pkg.sv
// Shared FFT constants and the feeder state encoding; also used by the magnitude/display path.
package fft_sink_feeder_pkg;

    localparam int unsigned FFT_LEN = 1024;
    localparam int unsigned AW      = 10;
    localparam int unsigned DW      = 12;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        SEND    = 2'd2
    } fft_state_e;

endpackage

// File: rtl/frame_ram.sv
// Simple dual-port frame buffer: one write port, one read port with 1-cycle registered read.
module frame_ram #(
    parameter int unsigned AW = 10,
    parameter int unsigned DW = 12
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];

    // Write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port; data appears the cycle after re.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fft_sink_feeder.sv
// Captures one frame of ADC samples into a buffer, then streams it to an FFT sink interface
// through a 2-entry prefetch stage that hides the buffer's read latency under backpressure.
module fft_sink_feeder #(
    parameter int unsigned FFT_LEN = fft_sink_feeder_pkg::FFT_LEN,
    parameter int unsigned AW      = fft_sink_feeder_pkg::AW,
    parameter int unsigned DW      = fft_sink_feeder_pkg::DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          adc_valid,
    input  logic [DW-1:0] adc_data,
    input  logic          sink_ready,
    output logic          sink_valid,
    output logic          sink_sop,
    output logic          sink_eop,
    output logic [DW-1:0] sink_real,
    output logic [DW-1:0] sink_imag,
    output logic [1:0]    sink_error,
    output logic          sink_inverse,
    output logic          busy,
    output logic          frame_done,
    output logic          overrun
);

    import fft_sink_feeder_pkg::*;

    localparam logic [AW-1:0] LAST_IDX = AW'(FFT_LEN - 1);

    fft_state_e    state_q, state_d;
    logic [AW-1:0] wcnt_q, wcnt_d;
    logic          overrun_q, overrun_d;
    logic          frame_done_q, frame_done_d;

    // Read side: raddr issues reads, k counts accepted transfers.
    logic [AW-1:0] raddr_q, raddr_d;
    logic          rd_done_q, rd_done_d;
    logic          rd_pend_q;
    logic [AW-1:0] k_q, k_d;

    // Two-entry prefetch FIFO.
    logic [DW-1:0] skid0_q, skid1_q;
    logic          wptr_q, wptr_d;
    logic          rptr_q, rptr_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [1:0]    occ;

    logic          ram_we;
    logic          ram_re;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic [DW-1:0] head;
    logic          xfer;

    // Offset binary to two's complement is an MSB flip.
    assign ram_wdata = {~adc_data[DW-1], adc_data[DW-2:0]};

    frame_ram #(
        .AW (AW),
        .DW (DW)
    ) u_frame_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wcnt_q),
        .wdata (ram_wdata),
        .re    (ram_re),
        .raddr (raddr_q),
        .rdata (ram_rdata)
    );

    assign head         = rptr_q ? skid1_q : skid0_q;
    assign sink_valid   = (state_q == SEND) && (cnt_q != 2'd0);
    assign sink_real    = sink_valid ? head : '0;
    assign sink_sop     = sink_valid && (k_q == '0);
    assign sink_eop     = sink_valid && (k_q == LAST_IDX);
    assign sink_imag    = '0;
    assign sink_error   = 2'b00;
    assign sink_inverse = 1'b0;
    assign busy         = (state_q != IDLE);
    assign frame_done   = frame_done_q;
    assign overrun      = overrun_q;
    assign xfer         = sink_valid && sink_ready;
    // Samples held plus the one in flight from the buffer.
    assign occ          = cnt_q + {1'b0, rd_pend_q};

    // Control FSM next state, capture writes and status flags.
    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        overrun_d    = overrun_q;
        frame_done_d = 1'b0;
        ram_we       = 1'b0;
        unique case (state_q)
            IDLE: begin
                // A start coinciding with frame_done is dropped; the requester re-issues it.
                if (start && !frame_done_q) begin
                    state_d   = CAPTURE;
                    wcnt_d    = '0;
                    overrun_d = 1'b0;
                end
            end
            CAPTURE: begin
                if (adc_valid) begin
                    ram_we = 1'b1;
                    wcnt_d = wcnt_q + 1'b1;
                    if (wcnt_q == LAST_IDX) begin
                        state_d = SEND;
                    end
                end
            end
            SEND: begin
                if (adc_valid) begin
                    overrun_d = 1'b1;
                end
                if (xfer && (k_q == LAST_IDX)) begin
                    state_d      = IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Read issue and prefetch FIFO bookkeeping; keeps at most two samples held or in flight.
    always_comb begin
        raddr_d   = raddr_q;
        rd_done_d = rd_done_q;
        k_d       = k_q;
        cnt_d     = cnt_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        ram_re    = 1'b0;
        if (state_q == SEND) begin
            ram_re = !rd_done_q && ((occ != 2'd2) || xfer);
            if (ram_re) begin
                raddr_d = raddr_q + 1'b1;
                if (raddr_q == LAST_IDX) begin
                    rd_done_d = 1'b1;
                end
            end
            if (rd_pend_q) begin
                wptr_d = ~wptr_q;
            end
            if (xfer) begin
                rptr_d = ~rptr_q;
                k_d    = k_q + 1'b1;
            end
            cnt_d = cnt_q + {1'b0, rd_pend_q} - {1'b0, xfer};
        end else begin
            raddr_d   = '0;
            rd_done_d = 1'b0;
            k_d       = '0;
            cnt_d     = '0;
            wptr_d    = 1'b0;
            rptr_d    = 1'b0;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wcnt_q       <= '0;
            overrun_q    <= 1'b0;
            frame_done_q <= 1'b0;
            raddr_q      <= '0;
            rd_done_q    <= 1'b0;
            rd_pend_q    <= 1'b0;
            k_q          <= '0;
            cnt_q        <= '0;
            wptr_q       <= 1'b0;
            rptr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            overrun_q    <= overrun_d;
            frame_done_q <= frame_done_d;
            raddr_q      <= raddr_d;
            rd_done_q    <= rd_done_d;
            rd_pend_q    <= ram_re;
            k_q          <= k_d;
            cnt_q        <= cnt_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
        end
    end

    // Prefetch data entries, loaded from the buffer read port when a read lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid0_q <= '0;
            skid1_q <= '0;
        end else if (rd_pend_q && (state_q == SEND)) begin
            if (wptr_q) begin
                skid1_q <= ram_rdata;
            end else begin
                skid0_q <= ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_fft_sink_feeder.sv
// Self-checking bench for fft_sink_feeder: table of frame scenarios with random data and
// random backpressure, checked against a queue-based model of the expected frame.
module tb_fft_sink_feeder;

    localparam int FFT_LEN = 1024;
    localparam int AW      = 10;
    localparam int DW      = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          adc_valid = 1'b0;
    logic [DW-1:0] adc_data = '0;
    logic          sink_ready = 1'b0;
    logic          sink_valid, sink_sop, sink_eop, sink_inverse;
    logic [DW-1:0] sink_real, sink_imag;
    logic [1:0]    sink_error;
    logic          busy, frame_done, overrun;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        bit ramp;
        int valid_every;
        int ready_pct;
        bit adc_in_send;
        bit start_mid_send;
        int reset_at_k;
        bit exp_done;
        bit exp_overrun;
    } scen_t;

    scen_t scen [6];

    fft_sink_feeder #(
        .FFT_LEN (FFT_LEN),
        .AW      (AW),
        .DW      (DW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .adc_valid    (adc_valid),
        .adc_data     (adc_data),
        .sink_ready   (sink_ready),
        .sink_valid   (sink_valid),
        .sink_sop     (sink_sop),
        .sink_eop     (sink_eop),
        .sink_real    (sink_real),
        .sink_imag    (sink_imag),
        .sink_error   (sink_error),
        .sink_inverse (sink_inverse),
        .busy         (busy),
        .frame_done   (frame_done),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 32'(sink_valid), 0);
        check({tag, "_sop_eop"}, 32'({sink_sop, sink_eop}), 0);
        check({tag, "_real"}, 32'(sink_real), 0);
        check({tag, "_imag"}, 32'(sink_imag), 0);
        check({tag, "_frame_done"}, 32'(frame_done), 0);
        check({tag, "_overrun"}, 32'(overrun), 0);
        check({tag, "_busy"}, 32'(busy), 0);
    endtask

    task automatic run_frame(input scen_t s);
        logic [DW-1:0] exp_q[$];
        int n, cyc, k, d, first_d, last_d;
        bit done, stall, did_reset;
        logic [DW-1:0] prev_real;
        logic prev_sop, prev_eop;

        start = 1'b1;
        adc_valid = 1'b0;
        sink_ready = 1'b0;
        step();
        start = 1'b0;
        check("busy_after_start", 32'(busy), 1);
        check("overrun_clear_on_start", 32'(overrun), 0);

        // Capture: model records each accepted sample with its MSB flipped.
        n = 0;
        cyc = 0;
        while (n < FFT_LEN) begin
            adc_valid = (cyc % s.valid_every) == 0;
            adc_data = s.ramp ? DW'(n) : DW'($urandom);
            if (adc_valid) exp_q.push_back(adc_data ^ 12'h800);
            step();
            cyc++;
            if (adc_valid) n++;
            check("no_valid_in_capture", 32'(sink_valid), 0);
        end

        // Send: d counts cycles since the last sample was written.
        adc_valid = s.adc_in_send;
        adc_data = DW'($urandom);
        k = 0; d = 1; first_d = 0; last_d = 0;
        done = 1'b0; stall = 1'b0; did_reset = 1'b0;
        prev_real = '0; prev_sop = 1'b0; prev_eop = 1'b0;
        while (!done && !did_reset && d < 6000) begin
            if (s.reset_at_k >= 0 && k == s.reset_at_k && sink_valid) begin
                rst_n = 1'b0;
                adc_valid = 1'b0;
                sink_ready = 1'b0;
                start = 1'b0;
                #1;
                check_all_zero("reset_mid_send");
                @(posedge clk);
                @(posedge clk);
                #1;
                check_all_zero("reset_held");
                @(negedge clk);
                rst_n = 1'b1;
                did_reset = 1'b1;
            end else begin
                if (sink_valid) begin
                    if (first_d == 0) begin
                        first_d = d;
                        check("first_valid_latency", 32'(d <= 3), 1);
                    end
                    check("sink_real", 32'(sink_real), 32'(exp_q[k]));
                    check("sink_sop", 32'(sink_sop), 32'(k == 0));
                    check("sink_eop", 32'(sink_eop), 32'(k == FFT_LEN - 1));
                end else begin
                    check("sop_eop_unqualified", 32'({sink_sop, sink_eop}), 0);
                end
                if (stall) begin
                    check("stall_valid_held", 32'(sink_valid), 1);
                    check("stall_real_held", 32'(sink_real), 32'(prev_real));
                    check("stall_sop_eop_held", 32'({sink_sop, sink_eop}),
                          32'({prev_sop, prev_eop}));
                end
                check("imag_err_inv_zero", 32'({sink_imag, sink_error, sink_inverse}), 0);
                check("no_early_frame_done", 32'(frame_done), 0);
                check("busy_in_send", 32'(busy), 1);
                sink_ready = ($urandom_range(99) < s.ready_pct);
                start = s.start_mid_send && (k == 300);
                stall = sink_valid && !sink_ready;
                prev_real = sink_real;
                prev_sop = sink_sop;
                prev_eop = sink_eop;
                if (sink_valid && sink_ready) begin
                    if (k == FFT_LEN - 1) begin
                        last_d = d;
                        done = 1'b1;
                    end
                    k++;
                end
                step();
                d++;
            end
        end
        start = 1'b0;

        check("frame_completed", 32'(done), 32'(s.exp_done));
        if (!done) return;
        check("no_bubbles", 32'((s.ready_pct < 100) || (last_d - first_d + 1 == FFT_LEN)), 1);
        check("valid_drops_after_eop", 32'(sink_valid), 0);
        check("frame_done_pulse", 32'(frame_done), 1);
        check("idle_after_frame", 32'(busy), 0);
        check("overrun_flag", 32'(overrun), 32'(s.exp_overrun));

        // Start coinciding with frame_done must be ignored.
        start = 1'b1;
        adc_valid = 1'b0;
        sink_ready = 1'b0;
        step();
        start = 1'b0;
        check("frame_done_one_cycle", 32'(frame_done), 0);
        check("start_with_done_ignored", 32'(busy), 0);
        step();
        check("no_second_frame", 32'(busy), 0);
        check("overrun_sticky_idle", 32'(overrun), 32'(s.exp_overrun));
    endtask

    initial begin
        //         ramp every rdy  ovr  mid  rst   done ovr_exp
        scen[0] = '{1'b1, 1, 100, 1'b0, 1'b0, -1,  1'b1, 1'b0};
        scen[1] = '{1'b1, 1, 50,  1'b0, 1'b0, -1,  1'b1, 1'b0};
        scen[2] = '{1'b0, 4, 100, 1'b0, 1'b0, -1,  1'b1, 1'b0};
        scen[3] = '{1'b0, 1, 70,  1'b1, 1'b1, -1,  1'b1, 1'b1};
        scen[4] = '{1'b0, 2, 100, 1'b1, 1'b0, 500, 1'b0, 1'b0};
        scen[5] = '{1'b0, 1, 60,  1'b0, 1'b0, -1,  1'b1, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset_state");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("idle_after_reset", 32'(busy), 0);

        // adc_valid in IDLE must neither start a frame nor set overrun.
        adc_valid = 1'b1;
        repeat (3) step();
        adc_valid = 1'b0;
        check("idle_ignores_adc_busy", 32'(busy), 0);
        check("idle_ignores_adc_overrun", 32'(overrun), 0);

        for (int i = 0; i < 6; i++) begin
            run_frame(scen[i]);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
